// File: rtl/core_seq.sv
// core_seq: main control sequencer of the multi-cycle RV32 core.
// Walks each instruction through fetch, decode, operand read, execute,
// optional data access and write-back, and diverts to a one-cycle trap
// state on illegal opcodes, fetch bus errors and memory timeouts.
module core_seq #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic [2:0]       state,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic             imem_err,
  output logic             ir_we,
  input  logic             illegal_insn,
  input  logic             is_ebreak,
  input  logic             is_load,
  input  logic             is_store,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             trap,
  output logic [3:0]       trap_cause,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    REG_READ  = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    MEM       = 3'd5,
    TRAP      = 3'd6,
    HALT      = 3'd7
  } seqState_t;

  // The wait counter never has to count past MEM_TIMEOUT when the timeout
  // is enabled; when it is disabled the counter simply wraps harmlessly.
  localparam int                WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V  = WAIT_W'(MEM_TIMEOUT);
  localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);

  localparam logic [3:0] CAUSE_INSN_FAULT  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

  seqState_t         r_state;
  seqState_t         w_nextState;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [CNT_W-1:0]  r_instret;
  logic [3:0]        r_trapCause;
  logic              w_timeoutHit;
  logic              w_waitInc;
  logic              w_waitClr;
  logic              w_causeLoad;
  logic [3:0]        w_causeNext;

  assign w_timeoutHit = TIMEOUT_EN && (r_waitCnt == TIMEOUT_V);

  // The wait counter restarts whenever a fresh memory request state is entered.
  assign w_waitClr = (w_nextState != r_state) &&
                     ((w_nextState == FETCH) || (w_nextState == MEM));

  assign state      = r_state;
  assign halted     = (r_state == HALT);
  assign instret    = r_instret;
  assign trap_cause = r_trapCause;

  // Next-state selection and strobe decode; reset silences every strobe.
  always_comb begin
    w_nextState = r_state;
    w_waitInc   = 1'b0;
    w_causeLoad = 1'b0;
    w_causeNext = 4'd0;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    pc_we       = 1'b0;
    trap        = 1'b0;
    case (r_state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && !imem_err) begin
          ir_we       = 1'b1;
          w_nextState = DECODE;
        end else if (imem_ready || w_timeoutHit) begin
          w_nextState = TRAP;
          w_causeLoad = 1'b1;
          w_causeNext = CAUSE_INSN_FAULT;
        end else begin
          w_waitInc = 1'b1;
        end
      end
      DECODE: begin
        if (illegal_insn) begin
          w_nextState = TRAP;
          w_causeLoad = 1'b1;
          w_causeNext = CAUSE_ILLEGAL;
        end else if (is_ebreak) begin
          w_nextState = HALT;
        end else begin
          w_nextState = REG_READ;
        end
      end
      REG_READ: begin
        w_nextState = EXECUTE;
      end
      EXECUTE: begin
        w_nextState = (is_load || is_store) ? MEM : WRITEBACK;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          w_nextState = WRITEBACK;
        end else if (w_timeoutHit) begin
          w_nextState = TRAP;
          w_causeLoad = 1'b1;
          w_causeNext = is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
        end else begin
          w_waitInc = 1'b1;
        end
      end
      WRITEBACK: begin
        pc_we       = 1'b1;
        w_nextState = FETCH;
      end
      TRAP: begin
        trap        = 1'b1;
        pc_we       = 1'b1;
        w_nextState = FETCH;
      end
      default: begin
        w_nextState = HALT;
      end
    endcase
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      pc_we    = 1'b0;
      trap     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Memory wait counter used for the access timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_waitCnt <= '0;
    end else if (w_waitClr) begin
      r_waitCnt <= '0;
    end else if (w_waitInc) begin
      r_waitCnt <= r_waitCnt + WAIT_W'(1);
    end
  end

  // Trap cause is captured on the way into TRAP and held until the next trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trapCause <= 4'd0;
    end else if (w_causeLoad) begin
      r_trapCause <= w_causeNext;
    end
  end

  // Retired-instruction counter advances once per write-back, wrapping freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
    end else if (r_state == WRITEBACK) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: self-checking bench for the core sequencer.
// A short-timeout, 4-bit-counter instance is checked by a directed vector
// table, hand-written corner sequences and a randomized run against a
// behavioural model; a second instance with the timeout disabled shares
// the same inputs.
module tb_core_seq;

  localparam int TO   = 4;
  localparam int CW   = 4;

  localparam int P_FETCH = 0;
  localparam int P_DEC   = 1;
  localparam int P_RR    = 2;
  localparam int P_EX    = 3;
  localparam int P_WB    = 4;
  localparam int P_MEM   = 5;
  localparam int P_TRAP  = 6;
  localparam int P_HALT  = 7;

  typedef enum int {K_ALU, K_LOAD, K_STORE, K_ILL, K_EBREAK} insnKind_t;

  typedef struct {
    logic [7:0] in;
    logic [2:0] eState;
    logic [5:0] eStrobes;
    logic [3:0] eCause;
    logic       eHalted;
    logic [3:0] eInstret;
  } vec_t;

  logic clk = 1'b0;
  logic rst, imemReady, imemErr, illegalInsn, isEbreak, isLoad, isStore, dmemReady;

  logic [2:0]    dState;
  logic          dImemReq, dIrWe, dDmemReq, dDmemWe, dPcWe, dTrap, dHalted;
  logic [3:0]    dCause;
  logic [CW-1:0] dInstret;

  logic [2:0]    bState;
  logic          bImemReq, bIrWe, bDmemReq, bDmemWe, bPcWe, bTrap, bHalted;
  logic [3:0]    bCause;
  logic [CW-1:0] bInstret;

  int total = 0;
  int bad   = 0;

  int        mPhase, mWait, mInstret, mCause;
  int        nPhase, nWait, nInstret, nCause;
  logic [5:0] eStrobes;
  insnKind_t kind;

  vec_t vecs[$];

  core_seq #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .state(dState),
    .imem_req(dImemReq), .imem_ready(imemReady), .imem_err(imemErr), .ir_we(dIrWe),
    .illegal_insn(illegalInsn), .is_ebreak(isEbreak), .is_load(isLoad), .is_store(isStore),
    .dmem_req(dDmemReq), .dmem_we(dDmemWe), .dmem_ready(dmemReady),
    .pc_we(dPcWe), .trap(dTrap), .trap_cause(dCause), .halted(dHalted), .instret(dInstret)
  );

  core_seq #(.MEM_TIMEOUT(0), .CNT_W(CW)) dutB (
    .clk(clk), .rst(rst), .state(bState),
    .imem_req(bImemReq), .imem_ready(imemReady), .imem_err(imemErr), .ir_we(bIrWe),
    .illegal_insn(illegalInsn), .is_ebreak(isEbreak), .is_load(isLoad), .is_store(isStore),
    .dmem_req(bDmemReq), .dmem_we(bDmemWe), .dmem_ready(dmemReady),
    .pc_we(bPcWe), .trap(bTrap), .trap_cause(bCause), .halted(bHalted), .instret(bInstret)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic [7:0] in, input logic [2:0] s, input logic [5:0] stb,
                                 input logic [3:0] c, input logic h, input logic [3:0] ir);
    vec_t v;
    v.in = in; v.eState = s; v.eStrobes = stb; v.eCause = c; v.eHalted = h; v.eInstret = ir;
    return v;
  endfunction

  // Inputs are {rst, imem_ready, imem_err, illegal, ebreak, load, store, dmem_ready}.
  task automatic applyStimulus(input logic [7:0] in);
    {rst, imemReady, imemErr, illegalInsn, isEbreak, isLoad, isStore, dmemReady} = in;
    @(negedge clk);
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobes are ordered {imem_req, ir_we, dmem_req, dmem_we, pc_we, trap}.
  task automatic checkAll(input string tag, input logic [2:0] s, input logic [5:0] stb,
                          input logic [3:0] c, input logic h, input logic [3:0] ir);
    checkOutput({tag, ".state"},   32'(dState), 32'(s));
    checkOutput({tag, ".strobes"}, 32'({dImemReq, dIrWe, dDmemReq, dDmemWe, dPcWe, dTrap}), 32'(stb));
    checkOutput({tag, ".cause"},   32'(dCause), 32'(c));
    checkOutput({tag, ".halted"},  32'(dHalted), 32'(h));
    checkOutput({tag, ".instret"}, 32'(dInstret), 32'(ir));
  endtask

  task automatic doReset;
    applyStimulus(8'b1000_0000);
    nextCycle();
  endtask

  // Runs one whole instruction with instant memory acknowledges.
  task automatic runInsn(input logic ld, input logic st);
    int n;
    n = (ld || st) ? 6 : 5;
    for (int c = 0; c < n; c++) begin
      applyStimulus({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ld, st, 1'b1});
      nextCycle();
    end
  endtask

  // Behavioural reference: what the sequencer must show this cycle and
  // where it must go, derived from the phase rules of the instruction flow.
  task automatic modelEval;
    logic [5:0] s;
    s = 6'b0;
    nPhase = mPhase; nWait = mWait; nInstret = mInstret; nCause = mCause;
    if (rst) begin
      nPhase = P_FETCH; nWait = 0; nInstret = 0; nCause = 0;
    end else begin
      if (mPhase == P_FETCH) begin
        s[5] = 1'b1;
        if (imemReady && !imemErr) begin
          s[4] = 1'b1; nPhase = P_DEC;
        end else if (imemReady || mWait == TO) begin
          nPhase = P_TRAP; nCause = 1;
        end else begin
          nWait = mWait + 1;
        end
      end else if (mPhase == P_DEC) begin
        nPhase = illegalInsn ? P_TRAP : (isEbreak ? P_HALT : P_RR);
        if (illegalInsn) nCause = 2;
      end else if (mPhase == P_RR) begin
        nPhase = P_EX;
      end else if (mPhase == P_EX) begin
        nPhase = (isLoad || isStore) ? P_MEM : P_WB;
      end else if (mPhase == P_MEM) begin
        s[3] = 1'b1; s[2] = isStore;
        if (dmemReady) nPhase = P_WB;
        else if (mWait == TO) begin
          nPhase = P_TRAP; nCause = isStore ? 7 : 5;
        end else nWait = mWait + 1;
      end else if (mPhase == P_WB) begin
        s[1] = 1'b1; nPhase = P_FETCH; nInstret = (mInstret + 1) % 16;
      end else if (mPhase == P_TRAP) begin
        s[1] = 1'b1; s[0] = 1'b1; nPhase = P_FETCH;
      end
      if (nPhase != mPhase && (nPhase == P_FETCH || nPhase == P_MEM)) nWait = 0;
    end
    eStrobes = s;
  endtask

  initial begin
    {rst, imemReady, imemErr, illegalInsn, isEbreak, isLoad, isStore, dmemReady} = 8'b1000_0000;
    nextCycle();
    nextCycle();

    // Directed table: ALU, load, store, illegal, fetch error, ebreak/halt, reset, priority.
    vecs.push_back(mkVec(8'b1000_0000, 3'd0, 6'b000000, 4'd0, 1'b0, 4'd0));
    vecs.push_back(mkVec(8'b0100_0000, 3'd0, 6'b110000, 4'd0, 1'b0, 4'd0));
    vecs.push_back(mkVec(8'b0100_0000, 3'd1, 6'b000000, 4'd0, 1'b0, 4'd0));
    vecs.push_back(mkVec(8'b0100_0000, 3'd2, 6'b000000, 4'd0, 1'b0, 4'd0));
    vecs.push_back(mkVec(8'b0100_0000, 3'd3, 6'b000000, 4'd0, 1'b0, 4'd0));
    vecs.push_back(mkVec(8'b0100_0000, 3'd4, 6'b000010, 4'd0, 1'b0, 4'd0));
    vecs.push_back(mkVec(8'b0100_0100, 3'd0, 6'b110000, 4'd0, 1'b0, 4'd1));
    vecs.push_back(mkVec(8'b0100_0100, 3'd1, 6'b000000, 4'd0, 1'b0, 4'd1));
    vecs.push_back(mkVec(8'b0100_0100, 3'd2, 6'b000000, 4'd0, 1'b0, 4'd1));
    vecs.push_back(mkVec(8'b0100_0100, 3'd3, 6'b000000, 4'd0, 1'b0, 4'd1));
    vecs.push_back(mkVec(8'b0100_0100, 3'd5, 6'b001000, 4'd0, 1'b0, 4'd1));
    vecs.push_back(mkVec(8'b0100_0100, 3'd5, 6'b001000, 4'd0, 1'b0, 4'd1));
    vecs.push_back(mkVec(8'b0100_0101, 3'd5, 6'b001000, 4'd0, 1'b0, 4'd1));
    vecs.push_back(mkVec(8'b0100_0100, 3'd4, 6'b000010, 4'd0, 1'b0, 4'd1));
    vecs.push_back(mkVec(8'b0100_0010, 3'd0, 6'b110000, 4'd0, 1'b0, 4'd2));
    vecs.push_back(mkVec(8'b0100_0010, 3'd1, 6'b000000, 4'd0, 1'b0, 4'd2));
    vecs.push_back(mkVec(8'b0100_0010, 3'd2, 6'b000000, 4'd0, 1'b0, 4'd2));
    vecs.push_back(mkVec(8'b0100_0010, 3'd3, 6'b000000, 4'd0, 1'b0, 4'd2));
    vecs.push_back(mkVec(8'b0100_0010, 3'd5, 6'b001100, 4'd0, 1'b0, 4'd2));
    vecs.push_back(mkVec(8'b0100_0010, 3'd5, 6'b001100, 4'd0, 1'b0, 4'd2));
    vecs.push_back(mkVec(8'b0100_0011, 3'd5, 6'b001100, 4'd0, 1'b0, 4'd2));
    vecs.push_back(mkVec(8'b0100_0010, 3'd4, 6'b000010, 4'd0, 1'b0, 4'd2));
    vecs.push_back(mkVec(8'b0101_0000, 3'd0, 6'b110000, 4'd0, 1'b0, 4'd3));
    vecs.push_back(mkVec(8'b0101_0000, 3'd1, 6'b000000, 4'd0, 1'b0, 4'd3));
    vecs.push_back(mkVec(8'b0101_0000, 3'd6, 6'b000011, 4'd2, 1'b0, 4'd3));
    vecs.push_back(mkVec(8'b0110_0000, 3'd0, 6'b100000, 4'd2, 1'b0, 4'd3));
    vecs.push_back(mkVec(8'b0000_0000, 3'd6, 6'b000011, 4'd1, 1'b0, 4'd3));
    vecs.push_back(mkVec(8'b0100_1000, 3'd0, 6'b110000, 4'd1, 1'b0, 4'd3));
    vecs.push_back(mkVec(8'b0100_1000, 3'd1, 6'b000000, 4'd1, 1'b0, 4'd3));
    vecs.push_back(mkVec(8'b0110_0001, 3'd7, 6'b000000, 4'd1, 1'b1, 4'd3));
    vecs.push_back(mkVec(8'b0100_0101, 3'd7, 6'b000000, 4'd1, 1'b1, 4'd3));
    vecs.push_back(mkVec(8'b1100_0001, 3'd7, 6'b000000, 4'd1, 1'b1, 4'd3));
    vecs.push_back(mkVec(8'b0000_0000, 3'd0, 6'b100000, 4'd0, 1'b0, 4'd0));
    vecs.push_back(mkVec(8'b0100_0000, 3'd0, 6'b110000, 4'd0, 1'b0, 4'd0));
    vecs.push_back(mkVec(8'b0001_1000, 3'd1, 6'b000000, 4'd0, 1'b0, 4'd0));
    vecs.push_back(mkVec(8'b0001_1000, 3'd6, 6'b000011, 4'd2, 1'b0, 4'd0));
    vecs.push_back(mkVec(8'b0000_0000, 3'd0, 6'b100000, 4'd2, 1'b0, 4'd0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].in);
      checkAll($sformatf("vec%0d", i), vecs[i].eState, vecs[i].eStrobes,
               vecs[i].eCause, vecs[i].eHalted, vecs[i].eInstret);
      nextCycle();
    end

    // Fetch timeout twice in a row; the disabled-timeout instance just keeps waiting.
    doReset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < TO + 1; c++) begin
        applyStimulus(8'b0000_0000);
        checkOutput("toFetch.state", 32'(dState), 32'(P_FETCH));
        checkOutput("toFetch.imemReq", 32'(dImemReq), 32'd1);
        checkOutput("noTo.state", 32'(bState), 32'(P_FETCH));
        checkOutput("noTo.quiet", 32'({bIrWe, bDmemReq, bDmemWe, bPcWe, bTrap, bHalted, bCause, bInstret, bImemReq}), 32'd1);
        nextCycle();
      end
      applyStimulus(8'b0000_0000);
      checkAll("toTrap", 3'd6, 6'b000011, 4'd1, 1'b0, 4'd0);
      checkOutput("noTo.stillFetch", 32'(bState), 32'(P_FETCH));
      nextCycle();
    end

    // Data timeout on a store: five MEM cycles then cause 7.
    doReset();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(8'b0100_0010);
      nextCycle();
    end
    for (int c = 0; c < TO + 1; c++) begin
      applyStimulus(8'b0000_0010);
      checkAll("stTo.mem", 3'd5, 6'b001100, 4'd0, 1'b0, 4'd0);
      nextCycle();
    end
    applyStimulus(8'b0000_0010);
    checkAll("stTo.trap", 3'd6, 6'b000011, 4'd7, 1'b0, 4'd0);
    nextCycle();

    // Reset pulsed in the middle of a load.
    doReset();
    runInsn(1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(8'b0100_0100);
      nextCycle();
    end
    applyStimulus(8'b0000_0100);
    checkAll("midMem.mem", 3'd5, 6'b001000, 4'd0, 1'b0, 4'd1);
    nextCycle();
    applyStimulus(8'b1000_0100);
    checkAll("midMem.rst", 3'd5, 6'b000000, 4'd0, 1'b0, 4'd1);
    nextCycle();
    applyStimulus(8'b0000_0000);
    checkAll("midMem.after", 3'd0, 6'b100000, 4'd0, 1'b0, 4'd0);
    nextCycle();

    // Halt holds through random bus activity until reset.
    doReset();
    runInsn(1'b0, 1'b0);
    applyStimulus(8'b0100_1000);
    nextCycle();
    applyStimulus(8'b0100_1000);
    nextCycle();
    for (int c = 0; c < 20; c++) begin
      applyStimulus({1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
      checkAll("halt", 3'd7, 6'b000000, 4'd0, 1'b1, 4'd1);
      nextCycle();
    end
    applyStimulus(8'b1000_0000);
    nextCycle();
    applyStimulus(8'b0000_0000);
    checkAll("halt.release", 3'd0, 6'b100000, 4'd0, 1'b0, 4'd0);
    nextCycle();

    // Counter wrap after sixteen retirements.
    doReset();
    for (int n = 0; n < 15; n++) runInsn(n[0], 1'b0);
    applyStimulus(8'b0000_0000);
    checkOutput("wrap.15", 32'(dInstret), 32'd15);
    runInsn(1'b0, 1'b1);
    applyStimulus(8'b0000_0000);
    checkOutput("wrap.0", 32'(dInstret), 32'd0);
    nextCycle();

    // Randomized run against the behavioural model.
    doReset();
    mPhase = P_FETCH; mWait = 0; mInstret = 0; mCause = 0;
    kind = K_ALU;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus({(($urandom_range(0, 49) == 0) || (mPhase == P_HALT && $urandom_range(0, 4) == 0)),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                     (kind == K_ILL), (kind == K_EBREAK), (kind == K_LOAD), (kind == K_STORE),
                     ($urandom_range(0, 2) == 0)});
      modelEval();
      checkAll("rand", 3'(mPhase), eStrobes, 4'(mCause), (mPhase == P_HALT), 4'(mInstret));
      nextCycle();
      mPhase = nPhase; mWait = nWait; mInstret = nInstret; mCause = nCause;
      if (mPhase == P_DEC) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: kind = K_ALU;
          4, 5:       kind = K_LOAD;
          6, 7:       kind = K_STORE;
          8:          kind = K_ILL;
          default:    kind = K_EBREAK;
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
